// File: rtl/sop_sweep_if.sv
// Output stream of sop_sweep: one beat per visible input combination,
// carrying the combination and its function value under valid/ready.
interface sop_sweep_if #(
  parameter int unsigned N = 3
) ();

  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_x;
  logic         out_s;

  modport master (
    output out_valid,
    output out_x,
    output out_s,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_x,
    input  out_s,
    output out_ready
  );

endinterface

// File: rtl/sop_sweep.sv
// sop_sweep: enumerates every input combination of an N-input truth table in
// ascending order, streaming (combination, value) beats and counting true
// minterms. Optional feature macro: SOP_SWEEP_ONES_CNT_EN builds the ones
// counter; without it ones_cnt is tied to zero.
module sop_sweep #(
  parameter int unsigned N = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [(1<<N)-1:0] tt,
  input  logic              only_ones,
  sop_sweep_if.master       out_if,
  output logic              busy,
  output logic              done,
  output logic [N:0]        ones_cnt
);

  localparam logic [N-1:0] IdxLast = '1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q;
  logic [(1<<N)-1:0] tt_q;
  logic              mode_q;
  logic [N-1:0]      idx_q;
  logic              busy_q;
  logic              done_q;

  logic cur_s;
  logic visible;
  logic advance;
  logic start_acc;

  // Beat decode comes straight from registers so a stalled beat stays put.
  always_comb begin
    cur_s     = tt_q[idx_q];
    visible   = !mode_q || cur_s;
    advance   = (state_q == StRun) && (!visible || out_if.out_ready);
    start_acc = (state_q == StIdle) && start;
  end

  assign out_if.out_valid = (state_q == StRun) && visible;
  assign out_if.out_x     = idx_q;
  assign out_if.out_s     = cur_s;
  assign busy             = busy_q;
  assign done             = done_q;

  // Sweep FSM with registered busy/done flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      tt_q    <= '0;
      mode_q  <= 1'b0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (start) begin
            tt_q    <= tt;
            mode_q  <= only_ones;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          if (advance) begin
            if (idx_q == IdxLast) begin
              // idx is left at the last combination; the next start clears it.
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              idx_q <= idx_q + N'(1);
            end
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifdef SOP_SWEEP_ONES_CNT_EN
  logic [N:0] ones_q;

  // Count true minterms as they are retired; N+1 bits so 2^N fits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_q <= '0;
    end else if (start_acc) begin
      ones_q <= '0;
    end else if (advance && cur_s) begin
      ones_q <= ones_q + (N+1)'(1);
    end
  end

  assign ones_cnt = ones_q;
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
  assign ones_cnt         = '0;
`endif

endmodule

// File: tb/tb_sop_sweep.sv
// Randomized scoreboard bench for sop_sweep (N=3).
module tb_sop_sweep;

  localparam int unsigned N = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       only_ones = 1'b0;
  logic [7:0] tt = '0;
  logic       busy;
  logic       done;
  logic [3:0] ones_cnt;

  sop_sweep_if #(.N(N)) bus ();

  sop_sweep #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .tt        (tt),
    .only_ones (only_ones),
    .out_if    (bus),
    .busy      (busy),
    .done      (done),
    .ones_cnt  (ones_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int sb[$];  // expected beats, encoded x*2+s

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on each handshake, checks stall stability.
  initial begin
    bit         stalled;
    logic [2:0] px;
    logic       ps;
    int         e;
    stalled = 0;
    px = '0;
    ps = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 0;
      end else begin
        if (stalled) begin
          chk("stall_valid", int'(bus.out_valid), 1);
          chk("stall_x", int'(bus.out_x), int'(px));
          chk("stall_s", int'(bus.out_s), int'(ps));
        end
        if (bus.out_valid) chk("done_with_valid", int'(done), 0);
        if (bus.out_valid && bus.out_ready) begin
          chk("beat_available", int'(sb.size() != 0), 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("beat_x", int'(bus.out_x), e / 2);
            chk("beat_s", int'(bus.out_s), e % 2);
          end
        end
        stalled = bus.out_valid && !bus.out_ready;
        px = bus.out_x;
        ps = bus.out_s;
      end
    end
  end

  // One sweep. pat: 0 always ready, 1 ready on even cycles, 2 random.
  task automatic sweep(input logic [7:0] tv, input logic m, input int pat, input bit poke);
    logic rdy [0:127];
    int   c;
    int   exp_done;
    int   exp_ones;
    int   got;
    for (int k = 0; k < 128; k++) begin
      if (k >= 100)      rdy[k] = 1'b1;
      else if (pat == 0) rdy[k] = 1'b1;
      else if (pat == 1) rdy[k] = (k % 2 == 0);
      else               rdy[k] = ($urandom_range(0, 3) != 0);
    end
    // Reference: walk the table, each visible beat waits for ready.
    c = 1;
    for (int i = 0; i < 8; i++) begin
      if (!m || tv[i]) begin
        sb.push_back(i * 2 + int'(tv[i]));
        while (!rdy[c]) c++;
      end
      c++;
    end
    exp_done = c;
`ifdef SOP_SWEEP_ONES_CNT_EN
    exp_ones = $countones(tv);
`else
    exp_ones = 0;
`endif
    tt = tv;
    only_ones = m;
    start = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    tt = 8'($urandom);
    only_ones = 1'($urandom);
    got = -1;
    for (int cc = 1; cc <= 120; cc++) begin
      bus.out_ready = rdy[cc];
      if (poke && cc == 3) begin
        start = 1'b1;
        tt = ~tv;
        only_ones = ~m;
      end
      if (cc == 4) start = 1'b0;
      @(negedge clk);
      chk("busy", int'(busy), int'(cc < exp_done));
      if (done) begin
        got = cc;
        break;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    chk("done_cycle", got, exp_done);
    chk("leftover_beats", sb.size(), 0);
    chk("ones_cnt", int'(ones_cnt), exp_ones);
    sb.delete();
    @(posedge clk);
    #1;
    chk("done_one_cycle", int'(done), 0);
    chk("idle_busy", int'(busy), 0);
    chk("ones_hold", int'(ones_cnt), exp_ones);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_x", int'(bus.out_x), 0);
    chk("rst_s", int'(bus.out_s), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ones", int'(ones_cnt), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    sweep(8'b01100110, 1'b0, 0, 1'b0);
    sweep(8'b01100110, 1'b1, 0, 1'b0);
    sweep(8'hFF, 1'b0, 1, 1'b0);
    sweep(8'h00, 1'b1, 0, 1'b0);
    sweep(8'hA5, 1'b0, 0, 1'b1);

    // Reset in the middle of a sweep, while beat 3 is presented.
    for (int i = 0; i < 8; i++) sb.push_back(i * 2 + int'(((8'hFF >> i) & 8'h01) != 0));
    tt = 8'hFF;
    only_ones = 1'b0;
    bus.out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("abort_valid", int'(bus.out_valid), 0);
    chk("abort_x", int'(bus.out_x), 0);
    chk("abort_s", int'(bus.out_s), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_ones", int'(ones_cnt), 0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_done", int'(done), 0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    sweep(8'h3C, 1'b0, 0, 1'b0);

    for (int r = 0; r < 20; r++) begin
      sweep(8'($urandom), 1'($urandom_range(0, 1)), 2, ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
